uart_rx_frame: RTL and testbench

Serial receive stage of the UART core: deframes the `rx` pin into parallel bytes using 16× oversampling ticks from the baud generator, and hands each completed frame to the receive FIFO. It honours the runtime frame format held in the control register: 7/8 data bits, optional even/odd parity, and 1, 1.5 or 2 stop bits. It flags parity and (optionally) framing errors per frame.

---
 rtl/uart_rx_frame_if.sv | 12 +
 rtl/uart_rx_frame.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// Receive-side frame delivery bundle between uart_rx_frame (master) and the receive FIFO (slave).
interface uart_rx_frame_if #(
  parameter int unsigned DBIT_MAX = 8
);
  logic [DBIT_MAX-1:0] rx_dout;
  logic                rx_done_tick;
  logic                parity_err;
  logic                frame_err;

  modport master (output rx_dout, rx_done_tick, parity_err, frame_err);
  modport slave  (input  rx_dout, rx_done_tick, parity_err, frame_err);
endinterface

// File: rtl/uart_rx_frame.sv
// UART serial receive deframer, 16x oversampled, runtime 7/8 data, parity, 1/1.5/2 stop.
// Optional UART_RX_FRAME_ERR_EN builds in stop-bit sampling, frame_err and the break re-arm guard.
module uart_rx_frame #(
  parameter int unsigned DBIT_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  input  logic             rx,
  input  logic             data_bits_7,
  input  logic             parity_en,
  input  logic             parity_even,
  input  logic [1:0]       stop_bits,
  uart_rx_frame_if.master  rx_if
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e              state_q;
  logic                rx_meta_q, rx_sync_q;
  logic [4:0]          s_q;
  logic [2:0]          n_q;
  logic [DBIT_MAX-1:0] b_q;
  logic                d7_q, pen_q, pev_q;
  logic [1:0]          sb_q;
  logic                perr_next_q;
  logic [DBIT_MAX-1:0] dout_q;
  logic                done_q, perr_q;

  logic [DBIT_MAX-1:0] frame_data;
  logic [2:0]          last_bit;
  logic [4:0]          stop_last;
  logic                armed;

`ifdef UART_RX_FRAME_ERR_EN
  logic stop_ok_q, ferr_q, armed_q;
  assign armed = armed_q;
  assign rx_if.frame_err = ferr_q;
`else
  assign armed = 1'b1;
  assign rx_if.frame_err = 1'b0;
`endif

  assign rx_if.rx_dout      = dout_q;
  assign rx_if.rx_done_tick = done_q;
  assign rx_if.parity_err   = perr_q;

  // 7-bit frames leave the data one place short of the LSB after shifting in at the MSB.
  always_comb begin
    frame_data = d7_q ? (b_q >> 1) : b_q;
    last_bit   = d7_q ? 3'(DBIT_MAX - 2) : 3'(DBIT_MAX - 1);
    stop_last  = 5'd31;
    unique case (sb_q)
      2'b00:   stop_last = 5'd15;
      2'b01:   stop_last = 5'd23;
      default: stop_last = 5'd31;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      d7_q        <= 1'b0;
      pen_q       <= 1'b0;
      pev_q       <= 1'b0;
      sb_q        <= '0;
      perr_next_q <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      stop_ok_q   <= 1'b1;
      ferr_q      <= 1'b0;
      armed_q     <= 1'b1;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      done_q    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      // After a break the line must go high before another start is accepted.
      if (rx_sync_q) armed_q <= 1'b1;
`endif
      unique case (state_q)
        IDLE: begin
          if (!rx_sync_q && armed) begin
            state_q     <= START;
            s_q         <= '0;
            n_q         <= '0;
            perr_next_q <= 1'b0;
            d7_q        <= data_bits_7;
            pen_q       <= parity_en;
            pev_q       <= parity_even;
            sb_q        <= stop_bits;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == 5'd7) begin
              s_q     <= '0;
              state_q <= rx_sync_q ? IDLE : DATA;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == 5'd15) begin
              s_q <= '0;
              b_q <= {rx_sync_q, b_q[DBIT_MAX-1:1]};
              if (n_q == last_bit) begin
                n_q     <= '0;
                state_q <= pen_q ? PARITY : STOP;
              end else begin
                n_q <= n_q + 3'd1;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s_q == 5'd15) begin
              s_q         <= '0;
              perr_next_q <= ((^frame_data) ^ rx_sync_q) != !pev_q;
              state_q     <= STOP;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
`ifdef UART_RX_FRAME_ERR_EN
            if (s_q == 5'd7) stop_ok_q <= rx_sync_q;
`endif
            if (s_q == stop_last) begin
              s_q     <= '0;
              state_q <= IDLE;
              done_q  <= 1'b1;
              dout_q  <= frame_data;
              perr_q  <= perr_next_q;
`ifdef UART_RX_FRAME_ERR_EN
              ferr_q  <= ~stop_ok_q;
              armed_q <= stop_ok_q;
`endif
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized frame bench for uart_rx_frame against a frame-level reference model.
module tb_uart_rx_frame;

`ifdef UART_RX_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int BIT_CLKS = 128;  // 16 ticks x 8 clocks

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick;
  logic       rx = 1'b1;
  logic       data_bits_7 = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_even = 1'b0;
  logic [1:0] stop_bits = 2'b00;
  logic [2:0] tick_cnt = '0;
  int         cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
    int         cyc;
  } ev_t;
  ev_t evq[$];

  logic [7:0] rs_dout;
  logic       rs_done, rs_perr, rs_ferr;

  uart_rx_frame_if #(.DBIT_MAX(8)) rx_if ();

  uart_rx_frame #(.DBIT_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .data_bits_7 (data_bits_7),
    .parity_en   (parity_en),
    .parity_even (parity_even),
    .stop_bits   (stop_bits),
    .rx_if       (rx_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    tick_cnt <= tick_cnt + 3'd1;
  end
  assign s_tick = (tick_cnt == 3'd7);

  always @(negedge clk) begin
    if (rx_if.rx_done_tick) evq.push_back('{rx_if.rx_dout, rx_if.parity_err, rx_if.frame_err, cyc});
  end

  function automatic logic [7:0] mdl_dout(input logic [7:0] d, input bit d7);
    return d7 ? (d & 8'h7f) : d;
  endfunction

  function automatic bit mdl_pbit(input logic [7:0] d, input bit d7, input bit even);
    int ones = $countones(mdl_dout(d, d7));
    return even ? bit'(ones % 2) : bit'(1 - ones % 2);
  endfunction

  function automatic int mdl_ticks(input bit d7, input bit pen, input logic [1:0] sb);
    int stop_t = (sb == 2'b00) ? 16 : (sb == 2'b01) ? 24 : 32;
    return 8 + 16 * ((d7 ? 7 : 8) + int'(pen)) + stop_t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    do @(negedge clk); while (tick_cnt != 3'd5);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit d7, input bit pen, input bit pev,
                            input logic [1:0] sb, input bit pflip, input bit slow,
                            input bit scramble, input int rst_bit, output int c_start);
    int nb = d7 ? 7 : 8;
    int stop_clks = (sb == 2'b00) ? 128 : (sb == 2'b01) ? 192 : 256;
    logic [7:0] dv = d;
    align();
    data_bits_7 = d7; parity_en = pen; parity_even = pev; stop_bits = sb;
    rx = 1'b0;
    c_start = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = dv[i];
      if (scramble && i == 2) begin
        data_bits_7 = 1'($urandom); parity_en = 1'($urandom);
        parity_even = 1'($urandom); stop_bits = 2'($urandom);
      end
      if (i == rst_bit) begin
        repeat (40) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rs_dout = rx_if.rx_dout; rs_done = rx_if.rx_done_tick;
        rs_perr = rx_if.parity_err; rs_ferr = rx_if.frame_err;
        repeat (BIT_CLKS - 42) @(negedge clk);
      end else begin
        repeat (BIT_CLKS) @(negedge clk);
      end
    end
    if (pen) begin
      rx = mdl_pbit(d, d7, pev) ^ pflip;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = ~slow;
    repeat (stop_clks) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] ed, input logic ep,
                              input logic ef, input int ec);
    ev_t ev;
    check({tag, "/pulses"}, 32'(evq.size()), 32'd1);
    if (evq.size() != 0) begin
      ev = evq.pop_front();
      check({tag, "/dout"}, 32'(ev.dout), 32'(ed));
      check({tag, "/parity_err"}, 32'(ev.perr), 32'(ep));
      check({tag, "/frame_err"}, 32'(ev.ferr), 32'(ef));
      check({tag, "/done_cycle"}, 32'(ev.cyc), 32'(ec));
    end
    evq.delete();
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input bit d7, input bit pen,
                       input bit pev, input logic [1:0] sb, input bit pflip, input bit slow,
                       input bit scramble);
    int c0;
    send_frame(d, d7, pen, pev, sb, pflip, slow, scramble, -1, c0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    expect_frame(tag, mdl_dout(d, d7), logic'(pen && pflip), logic'(ERR_EN && slow),
                 c0 + 3 + 8 * mdl_ticks(d7, pen, sb));
  endtask

  initial begin
    int c0;
    logic [7:0] rd;
    bit r7, rpe, rpv, rpf;
    logic [1:0] rsb;

    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset/dout", 32'(rx_if.rx_dout), 32'h0);
    check("reset/done", 32'(rx_if.rx_done_tick), 32'h0);
    check("reset/parity_err", 32'(rx_if.parity_err), 32'h0);
    check("reset/frame_err", 32'(rx_if.frame_err), 32'h0);

    frame("8N2_32", 8'h32, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    frame("7N15_41", 8'h41, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    frame("7N15_67", 8'h67, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    frame("7N15_bit7", 8'hC3, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    frame("7E1_49_ok", 8'h49, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    frame("7E1_49_bad", 8'h49, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    frame("7O1_49_ok", 8'h49, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Start-bit glitch: four ticks low must not produce a frame.
    align();
    data_bits_7 = 1'b0; parity_en = 1'b0; stop_bits = 2'b00;
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch/pulses", 32'(evq.size()), 32'd0);
    evq.delete();
    frame("8N1_A5", 8'hA5, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset pulse in data bit 3: outputs clear, no pulse for the cut frame.
    send_frame(8'h57, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3, c0);
    check("midreset/dout", 32'(rs_dout), 32'h0);
    check("midreset/done", 32'(rs_done), 32'h0);
    check("midreset/parity_err", 32'(rs_perr), 32'h0);
    check("midreset/frame_err", 32'(rs_ferr), 32'h0);
    check("midreset/pulses", 32'(evq.size()), 32'd0);
    repeat (14 * BIT_CLKS) @(negedge clk);
    evq.delete();
    frame("8N1_57", 8'h57, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    frame("8N1_18_stoplow", 8'h18, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    repeat (14 * BIT_CLKS) @(negedge clk);
    evq.delete();

`ifdef UART_RX_FRAME_ERR_EN
    // Break: one frame of zeros with frame_err, then no re-arm while the line stays low.
    align();
    data_bits_7 = 1'b0; parity_en = 1'b0; stop_bits = 2'b00;
    rx = 1'b0;
    c0 = cyc;
    repeat (24 * BIT_CLKS) @(negedge clk);
    expect_frame("break", 8'h00, 1'b0, 1'b1, c0 + 3 + 8 * mdl_ticks(1'b0, 1'b0, 2'b00));
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    frame("after_break", 8'h5A, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom); r7 = 1'($urandom); rpe = 1'($urandom);
      rpv = 1'($urandom); rpf = 1'($urandom); rsb = 2'($urandom);
      frame($sformatf("rand%0d", k), rd, r7, rpe, rpv, rsb, rpf, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
